scene_loader: RTL

//   Reprogramming controller for the scene buffer RAM write port. Receives a byte stream
//   (e.g. from the UART receiver), frames it into packets, assembles OBJ_BITS-wide object

---
 rtl/scene_loader.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/scene_loader.sv
// -----------------------------------------------------------------------------
// scene_loader
//   Reprogramming controller for the scene buffer RAM write port. Frames an
//   incoming byte stream into packets (0xA5 sync, object count N, then
//   N*BYTES_PER_OBJ payload bytes), assembles OBJ_BITS-wide object words
//   LSB-first and writes them to consecutive RAM addresses starting at 0.
//   num_objs is only updated after a complete packet, so a reader never sees
//   a count that refers to partially loaded objects.
//
// Ports
//   clk, rst   clock; synchronous active-high reset
//   rx_data    received byte
//   rx_valid   rx_data valid this cycle (no backpressure)
//   wr_en      RAM write strobe, one pulse per assembled object
//   wr_addr    RAM write address (object index)
//   wr_data    RAM write data (assembled object word)
//   num_objs   committed object count
//   loading    high while a packet is in progress
//   commit     one-cycle pulse: num_objs has just taken a new value
//   err        one-cycle pulse: packet aborted (bad count or timeout)
// -----------------------------------------------------------------------------
module scene_loader #(
    parameter int unsigned OBJ_BITS            = 673,
    parameter int unsigned MAX_SCENE_BUF_DEPTH = 64,
    parameter int unsigned BYTES_PER_OBJ       = (OBJ_BITS + 7) / 8,
    parameter int unsigned TIMEOUT_CYCLES      = 1000000,
    parameter int unsigned DEFAULT_NUM_OBJS    = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [7:0]                             rx_data,
    input  logic                                   rx_valid,
    output logic                                   wr_en,
    output logic [$clog2(MAX_SCENE_BUF_DEPTH)-1:0] wr_addr,
    output logic [OBJ_BITS-1:0]                    wr_data,
    output logic [$clog2(MAX_SCENE_BUF_DEPTH):0]   num_objs,
    output logic                                   loading,
    output logic                                   commit,
    output logic                                   err
);

    localparam int unsigned AW    = $clog2(MAX_SCENE_BUF_DEPTH);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned ASM_W = BYTES_PER_OBJ * 8;
    localparam int unsigned BW    = (BYTES_PER_OBJ > 1) ? $clog2(BYTES_PER_OBJ) : 1;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_PAYLOAD,
        ST_COMMIT
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       n_q, n_d;
    logic [CW-1:0]       obj_q, obj_d;
    logic [BW-1:0]       byte_q, byte_d;
    logic [ASM_W-1:0]    asm_q, asm_d;
    logic [TW-1:0]       tmo_q, tmo_d;
    logic                wr_en_q, wr_en_d;
    logic [AW-1:0]       wr_addr_q, wr_addr_d;
    logic [OBJ_BITS-1:0] wr_data_q, wr_data_d;
    logic [CW-1:0]       num_q, num_d;
    logic                commit_q, commit_d;
    logic                err_q, err_d;

    logic                tmo_hit;

    // Fires on the last tolerated idle cycle, so the abort lands exactly
    // TIMEOUT_CYCLES idle cycles after the last accepted byte.
    assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        obj_d     = obj_q;
        byte_d    = byte_q;
        asm_d     = asm_q;
        tmo_d     = tmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        num_d     = num_q;
        commit_d  = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (rx_valid && rx_data == 8'hA5) begin
                    state_d = ST_COUNT;
                end
            end

            ST_COUNT: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    if (rx_data == 8'h00 || rx_data > 8'(MAX_SCENE_BUF_DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d     = CW'(rx_data);
                        obj_d   = '0;
                        byte_d  = '0;
                        state_d = ST_PAYLOAD;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_PAYLOAD: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    // Byte k of the object goes to bits [8k+7:8k]; every byte
                    // slot is rewritten per object, so no clearing is needed.
                    for (int unsigned k = 0; k < BYTES_PER_OBJ; k++) begin
                        if (byte_q == BW'(k)) begin
                            asm_d[8*k +: 8] = rx_data;
                        end
                    end
                    if (byte_q == BW'(BYTES_PER_OBJ - 1)) begin
                        byte_d    = '0;
                        wr_en_d   = 1'b1;
                        wr_addr_d = obj_q[AW-1:0];
                        wr_data_d = asm_d[OBJ_BITS-1:0];
                        obj_d     = obj_q + 1'b1;
                        if (obj_q + 1'b1 == n_q) begin
                            state_d = ST_COMMIT;
                        end
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_COMMIT: begin
                // Any byte arriving here is dropped.
                tmo_d    = '0;
                num_d    = n_q;
                commit_d = 1'b1;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            obj_q     <= '0;
            byte_q    <= '0;
            asm_q     <= '0;
            tmo_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            num_q     <= CW'(DEFAULT_NUM_OBJS);
            commit_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            obj_q     <= obj_d;
            byte_q    <= byte_d;
            asm_q     <= asm_d;
            tmo_q     <= tmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            num_q     <= num_d;
            commit_q  <= commit_d;
            err_q     <= err_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign num_objs = num_q;
    assign commit   = commit_q;
    assign err      = err_q;
    assign loading  = (state_q != ST_IDLE);

endmodule
